// File: rtl/word_queue_row.sv
// One storage row of the word queue: a plain data register written when both
// its row select and the queue-wide write enable are high. Contents are never reset.
module queue_word_row #(
   parameter int numOfBit = 4
) (
   input  logic                Clk,
   input  logic                Sel,
   input  logic                WrEn,
   input  logic [numOfBit-1:0] D,
   output logic [numOfBit-1:0] Q
);

   logic [numOfBit-1:0] data_q;

   always_ff @(posedge Clk) begin
      if (Sel && WrEn) begin
         data_q <= D;
      end
   end

   assign Q = data_q;

endmodule

// File: rtl/word_queue.sv
// Synchronous FIFO of DEPTH words with count-derived flags, sticky error flags
// and a selectable show-ahead (FWFT=1) or registered (FWFT=0) read port.
module word_queue #(
   parameter int numOfBit = 4,
   parameter int DEPTH    = 4,
   parameter int AF_LEVEL = DEPTH - 1,
   parameter int AE_LEVEL = 1,
   parameter int FWFT     = 1
) (
   input  logic                         Clk,
   input  logic                         Rst_n,
   input  logic [numOfBit-1:0]          DataIn,
   input  logic                         Push,
   input  logic                         Pop,
   input  logic                         ClearErr,
   output logic [numOfBit-1:0]          DataOut,
   output logic                         Full,
   output logic                         Empty,
   output logic                         AlmostFull,
   output logic                         AlmostEmpty,
   output logic [$clog2(DEPTH+1)-1:0]   Count,
   output logic                         Overflow,
   output logic                         Underflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

   logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       count_q, count_d;
   logic                ovf_q, ovf_d;
   logic                unf_q, unf_d;
   logic                push_acc, pop_acc;
   logic [numOfBit-1:0] row_q [DEPTH];

   // Flags come straight from the count register so they always agree with Count.
   assign Full        = (count_q == DEPTH_C);
   assign Empty       = (count_q == '0);
   assign AlmostFull  = (count_q >= AF_C);
   assign AlmostEmpty = (count_q <= AE_C);
   assign Count       = count_q;
   assign Overflow    = ovf_q;
   assign Underflow   = unf_q;

   always_comb begin
      pop_acc  = Pop & ~Empty;
      // A pop in the same cycle frees a slot, so a full queue still takes the push.
      push_acc = Push & (~Full | pop_acc);
      wr_ptr_d = wr_ptr_q + PW'(push_acc);
      rd_ptr_d = rd_ptr_q + PW'(pop_acc);
      count_d  = count_q + CW'(push_acc) - CW'(pop_acc);

      ovf_d = ovf_q;
      unf_d = unf_q;
      if (ClearErr) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end
      if (Push && Full && !Pop) begin
         ovf_d = 1'b1;
      end
      if (Pop && Empty) begin
         unf_d = 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_row
      queue_word_row #(.numOfBit(numOfBit)) u_row (
         .Clk  (Clk),
         .Sel  (wr_ptr_q == PW'(g)),
         .WrEn (push_acc),
         .D    (DataIn),
         .Q    (row_q[g])
      );
   end

   if (FWFT != 0) begin : g_fwft
      assign DataOut = row_q[rd_ptr_q];
   end else begin : g_reg
      logic [numOfBit-1:0] dout_q, dout_d;

      // Registered read: the head word is captured only on an accepted pop.
      assign dout_d = pop_acc ? row_q[rd_ptr_q] : dout_q;

      always_ff @(posedge Clk or negedge Rst_n) begin
         if (!Rst_n) begin
            dout_q <= '0;
         end else begin
            dout_q <= dout_d;
         end
      end

      assign DataOut = dout_q;
   end

endmodule

// File: tb/tb_word_queue.sv
// Directed bench for word_queue: a show-ahead instance and a registered-read
// instance share clock and reset; each scenario task checks its own results.
module tb_word_queue;

   logic       Clk = 1'b0;
   logic       Rst_n = 1'b1;

   logic [3:0] DataIn = '0;
   logic       Push = 1'b0, Pop = 1'b0, ClearErr = 1'b0;
   logic [3:0] DataOut;
   logic       Full, Empty, AlmostFull, AlmostEmpty, Overflow, Underflow;
   logic [2:0] Count;

   logic [3:0] rDataIn = '0;
   logic       rPush = 1'b0, rPop = 1'b0, rClearErr = 1'b0;
   logic [3:0] rDataOut;
   logic       rFull, rEmpty, rAlmostFull, rAlmostEmpty, rOverflow, rUnderflow;
   logic [2:0] rCount;

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   word_queue #(.numOfBit(4), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .DataIn(DataIn), .Push(Push), .Pop(Pop),
      .ClearErr(ClearErr), .DataOut(DataOut), .Full(Full), .Empty(Empty),
      .AlmostFull(AlmostFull), .AlmostEmpty(AlmostEmpty), .Count(Count),
      .Overflow(Overflow), .Underflow(Underflow)
   );

   word_queue #(.numOfBit(4), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) dut_r (
      .Clk(Clk), .Rst_n(Rst_n), .DataIn(rDataIn), .Push(rPush), .Pop(rPop),
      .ClearErr(rClearErr), .DataOut(rDataOut), .Full(rFull), .Empty(rEmpty),
      .AlmostFull(rAlmostFull), .AlmostEmpty(rAlmostEmpty), .Count(rCount),
      .Overflow(rOverflow), .Underflow(rUnderflow)
   );

   task automatic step(input logic push, input logic pop, input logic [3:0] d);
      Push = push; Pop = pop; DataIn = d;
      @(posedge Clk); #1;
      Push = 1'b0; Pop = 1'b0;
   endtask

   task automatic rstep(input logic push, input logic pop, input logic [3:0] d);
      rPush = push; rPop = pop; rDataIn = d;
      @(posedge Clk); #1;
      rPush = 1'b0; rPop = 1'b0;
   endtask

   task automatic test_reset();
      #2 Rst_n = 1'b0;
      @(posedge Clk); @(posedge Clk); #1;
      checks++;
      if ({Count, Empty, Full, AlmostEmpty, AlmostFull, Overflow, Underflow} !== 9'b000_1010_00) begin
         errors++;
         $display("FAIL reset_flags: got cnt=%0d E=%b F=%b AE=%b AF=%b O=%b U=%b, want cnt=0 E=1 F=0 AE=1 AF=0 O=0 U=0",
                  Count, Empty, Full, AlmostEmpty, AlmostFull, Overflow, Underflow);
      end
      checks++;
      if (rDataOut !== 4'h0 || rCount !== 3'd0 || rEmpty !== 1'b1) begin
         errors++;
         $display("FAIL reset_reg: got dout=%h cnt=%0d E=%b, want dout=0 cnt=0 E=1", rDataOut, rCount, rEmpty);
      end
      Rst_n = 1'b1;
   endtask

   task automatic test_fill();
      step(1, 0, 4'hF);
      checks++;
      if (Count !== 3'd1 || Empty !== 1'b0 || DataOut !== 4'hF || AlmostEmpty !== 1'b1) begin
         errors++;
         $display("FAIL fill_1: got cnt=%0d E=%b AE=%b dout=%h, want cnt=1 E=0 AE=1 dout=f", Count, Empty, AlmostEmpty, DataOut);
      end
      step(1, 0, 4'h2);
      checks++;
      if (Count !== 3'd2 || AlmostEmpty !== 1'b0 || AlmostFull !== 1'b0) begin
         errors++;
         $display("FAIL fill_2: got cnt=%0d AE=%b AF=%b, want cnt=2 AE=0 AF=0", Count, AlmostEmpty, AlmostFull);
      end
      step(1, 0, 4'hA);
      checks++;
      if (Count !== 3'd3 || AlmostFull !== 1'b1 || Full !== 1'b0 || DataOut !== 4'hF) begin
         errors++;
         $display("FAIL fill_3: got cnt=%0d AF=%b F=%b dout=%h, want cnt=3 AF=1 F=0 dout=f", Count, AlmostFull, Full, DataOut);
      end
   endtask

   task automatic test_overflow_drain();
      logic [3:0] exp [4] = '{4'hF, 4'h2, 4'hA, 4'h5};
      step(1, 0, 4'h5);
      checks++;
      if (Count !== 3'd4 || Full !== 1'b1 || Overflow !== 1'b0) begin
         errors++;
         $display("FAIL full_4: got cnt=%0d F=%b O=%b, want cnt=4 F=1 O=0", Count, Full, Overflow);
      end
      step(1, 0, 4'h7);
      checks++;
      if (Count !== 3'd4 || Overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow: got cnt=%0d O=%b, want cnt=4 O=1", Count, Overflow);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (DataOut !== exp[i]) begin
            errors++;
            $display("FAIL drain_%0d: got %h, want %h", i, DataOut, exp[i]);
         end
         step(0, 1, 4'h0);
         if (i == 0) begin
            checks++;
            if (Full !== 1'b0 || Count !== 3'd3) begin
               errors++;
               $display("FAIL pop_unfull: got F=%b cnt=%0d, want F=0 cnt=3", Full, Count);
            end
         end
      end
      checks++;
      if (Empty !== 1'b1 || Count !== 3'd0) begin
         errors++;
         $display("FAIL drained_empty: got E=%b cnt=%0d, want E=1 cnt=0", Empty, Count);
      end
   endtask

   task automatic test_underflow_clear();
      step(0, 1, 4'h0);
      checks++;
      if (Underflow !== 1'b1 || Count !== 3'd0 || Overflow !== 1'b1) begin
         errors++;
         $display("FAIL underflow: got U=%b O=%b cnt=%0d, want U=1 O=1 cnt=0", Underflow, Overflow, Count);
      end
      ClearErr = 1'b1;
      step(0, 0, 4'h0);
      ClearErr = 1'b0;
      checks++;
      if (Underflow !== 1'b0 || Overflow !== 1'b0) begin
         errors++;
         $display("FAIL clear_err: got U=%b O=%b, want U=0 O=0", Underflow, Overflow);
      end
      // A new underflow in the same cycle as ClearErr must win.
      ClearErr = 1'b1;
      step(0, 1, 4'h0);
      ClearErr = 1'b0;
      checks++;
      if (Underflow !== 1'b1) begin
         errors++;
         $display("FAIL set_beats_clear: got U=%b, want U=1", Underflow);
      end
      ClearErr = 1'b1;
      step(0, 0, 4'h0);
      ClearErr = 1'b0;
   endtask

   task automatic test_empty_pushpop();
      step(1, 1, 4'hC);
      checks++;
      if (Count !== 3'd1 || Underflow !== 1'b1 || DataOut !== 4'hC) begin
         errors++;
         $display("FAIL empty_pushpop: got cnt=%0d U=%b dout=%h, want cnt=1 U=1 dout=c", Count, Underflow, DataOut);
      end
      step(0, 1, 4'h0);
      ClearErr = 1'b1;
      step(0, 0, 4'h0);
      ClearErr = 1'b0;
   endtask

   task automatic test_full_pushpop();
      logic [3:0] exp [4] = '{4'h2, 4'hA, 4'h5, 4'h9};
      step(1, 0, 4'h1);
      step(1, 0, 4'h2);
      step(1, 0, 4'hA);
      step(1, 0, 4'h5);
      step(1, 1, 4'h9);
      checks++;
      if (Count !== 3'd4 || Full !== 1'b1 || Overflow !== 1'b0) begin
         errors++;
         $display("FAIL full_pushpop: got cnt=%0d F=%b O=%b, want cnt=4 F=1 O=0", Count, Full, Overflow);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (DataOut !== exp[i]) begin
            errors++;
            $display("FAIL full_drain_%0d: got %h, want %h", i, DataOut, exp[i]);
         end
         step(0, 1, 4'h0);
      end
   endtask

   task automatic test_back_to_back();
      step(1, 0, 4'h0);
      for (int i = 1; i < 10; i++) begin
         checks++;
         if (DataOut !== 4'(i - 1) || Count !== 3'd1) begin
            errors++;
            $display("FAIL wrap_%0d: got dout=%h cnt=%0d, want dout=%h cnt=1", i, DataOut, Count, 4'(i - 1));
         end
         step(1, 1, 4'(i));
      end
      checks++;
      if (DataOut !== 4'h9) begin
         errors++;
         $display("FAIL wrap_last: got %h, want 9", DataOut);
      end
      step(0, 1, 4'h0);
      checks++;
      if (Empty !== 1'b1 || Overflow !== 1'b0 || Underflow !== 1'b0) begin
         errors++;
         $display("FAIL wrap_flags: got E=%b O=%b U=%b, want E=1 O=0 U=0", Empty, Overflow, Underflow);
      end
   endtask

   task automatic test_registered_read();
      rstep(1, 0, 4'h3);
      checks++;
      if (rDataOut !== 4'h0) begin
         errors++;
         $display("FAIL reg_before_pop: got %h, want 0", rDataOut);
      end
      rstep(0, 1, 4'h0);
      checks++;
      if (rDataOut !== 4'h3 || rEmpty !== 1'b1) begin
         errors++;
         $display("FAIL reg_pop: got dout=%h E=%b, want dout=3 E=1", rDataOut, rEmpty);
      end
      rstep(0, 0, 4'h0);
      rstep(0, 0, 4'h0);
      rstep(0, 1, 4'h0);
      checks++;
      if (rDataOut !== 4'h3 || rUnderflow !== 1'b1) begin
         errors++;
         $display("FAIL reg_hold: got dout=%h U=%b, want dout=3 U=1", rDataOut, rUnderflow);
      end
   endtask

   task automatic test_async_reset();
      rstep(1, 0, 4'h1);
      step(1, 0, 4'hE);
      Push = 1'b1; DataIn = 4'h4;
      rPush = 1'b1; rDataIn = 4'h2;
      #3 Rst_n = 1'b0;
      #1;
      checks++;
      if (rDataOut !== 4'h0 || rCount !== 3'd0 || rEmpty !== 1'b1 || rUnderflow !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_reg: got dout=%h cnt=%0d E=%b U=%b, want 0 0 1 0", rDataOut, rCount, rEmpty, rUnderflow);
      end
      checks++;
      if (Count !== 3'd0 || Empty !== 1'b1) begin
         errors++;
         $display("FAIL async_reset_fwft: got cnt=%0d E=%b, want cnt=0 E=1", Count, Empty);
      end
      Push = 1'b0; rPush = 1'b0;
      @(posedge Clk); #1;
      Rst_n = 1'b1;
      step(1, 0, 4'h6);
      checks++;
      if (DataOut !== 4'h6 || Count !== 3'd1) begin
         errors++;
         $display("FAIL after_reset_fwft: got dout=%h cnt=%0d, want 6 1", DataOut, Count);
      end
      rstep(1, 0, 4'hB);
      rstep(0, 1, 4'h0);
      checks++;
      if (rDataOut !== 4'hB || rEmpty !== 1'b1) begin
         errors++;
         $display("FAIL after_reset_reg: got dout=%h E=%b, want b 1", rDataOut, rEmpty);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_overflow_drain();
      test_underflow_clear();
      test_empty_pushpop();
      test_full_pushpop();
      test_back_to_back();
      test_registered_read();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
